// File: rtl/i2c_bus_monitor_if.sv
// Pad inputs and per-byte/bus-status outputs of the passive I2C monitor.
// The slave side is the monitor; the master side is whatever drives the pads and consumes the records.
interface i2c_bus_monitor_if;
  logic       scl_pad_i;
  logic       sda_pad_i;
  logic       start_o;
  logic       rstart_o;
  logic       stop_o;
  logic       bus_busy_o;
  logic       byte_valid_o;
  logic [7:0] byte_data_o;
  logic       byte_ack_o;
  logic       byte_is_addr_o;
  logic       err_o;

  modport master (
    output scl_pad_i, sda_pad_i,
    input  start_o, rstart_o, stop_o, bus_busy_o, byte_valid_o,
    input  byte_data_o, byte_ack_o, byte_is_addr_o, err_o
  );

  modport slave (
    input  scl_pad_i, sda_pad_i,
    output start_o, rstart_o, stop_o, bus_busy_o, byte_valid_o,
    output byte_data_o, byte_ack_o, byte_is_addr_o, err_o
  );
endinterface

// File: rtl/i2c_bus_monitor.sv
// Passive I2C observer: synchronises and deglitches SCL/SDA, decodes START/Sr/STOP
// and reassembles each byte plus its ACK bit. Never drives the bus.
module i2c_bus_monitor #(
  parameter int FILTER_LEN = 3
) (
  input logic               wb_clk_i,
  input logic               wb_rst_i,
  i2c_bus_monitor_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DATA, ACK} state_t;

  localparam logic [3:0] FILTER_LIMIT = 4'(FILTER_LEN - 1);

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] filt;
  logic [1:0] dly;
  logic [3:0] fcnt [2];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      dly     <= 2'b11;
      fcnt[0] <= 4'd0;
      fcnt[1] <= 4'd0;
    end else begin
      sync1 <= {bus.sda_pad_i, bus.scl_pad_i};
      sync2 <= sync1;
      dly   <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= 4'd0;
        end else if (fcnt[i] == FILTER_LIMIT) begin
          filt[i] <= sync2[i];
          fcnt[i] <= 4'd0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_d, sda_d;
  logic start_det, stop_det, scl_rise;

  assign scl_f = filt[0];
  assign sda_f = filt[1];
  assign scl_d = dly[0];
  assign sda_d = dly[1];

  // Requiring SCL high on both the current and delayed sample rejects SDA
  // edges that coincide with an SCL edge.
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
  assign scl_rise  = ~scl_d & scl_f;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       addr_flag;
  logic       partial;

  logic       start_q, rstart_q, stop_q, busy_q, valid_q, ack_q, is_addr_q, err_q;
  logic [7:0] data_q;

  assign partial = (bit_cnt != 3'd0) || (state == ACK);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'd0;
      addr_flag <= 1'b0;
      start_q   <= 1'b0;
      rstart_q  <= 1'b0;
      stop_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= 8'd0;
      ack_q     <= 1'b0;
      is_addr_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      start_q  <= 1'b0;
      rstart_q <= 1'b0;
      stop_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      if (start_det) begin
        if (state == IDLE) begin
          start_q <= 1'b1;
          busy_q  <= 1'b1;
        end else begin
          rstart_q <= 1'b1;
          err_q    <= partial;
        end
        state     <= DATA;
        bit_cnt   <= 3'd0;
        addr_flag <= 1'b1;
      end else if (stop_det) begin
        stop_q  <= 1'b1;
        err_q   <= (state != IDLE) && partial;
        busy_q  <= 1'b0;
        state   <= IDLE;
        bit_cnt <= 3'd0;
      end else if (scl_rise) begin
        case (state)
          DATA: begin
            shift   <= {shift[6:0], sda_f};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ACK;
          end
          ACK: begin
            valid_q   <= 1'b1;
            data_q    <= shift;
            ack_q     <= ~sda_f;
            is_addr_q <= addr_flag;
            addr_flag <= 1'b0;
            bit_cnt   <= 3'd0;
            state     <= DATA;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.start_o        = start_q;
  assign bus.rstart_o       = rstart_q;
  assign bus.stop_o         = stop_q;
  assign bus.bus_busy_o     = busy_q;
  assign bus.byte_valid_o   = valid_q;
  assign bus.byte_data_o    = data_q;
  assign bus.byte_ack_o     = ack_q;
  assign bus.byte_is_addr_o = is_addr_q;
  assign bus.err_o          = err_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Drives I2C pad waveforms and compares the monitor's event stream against a
// transaction-level model of the bus rules.
module tb_i2c_bus_monitor;
  localparam int FILTER_LEN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_bus_monitor_if bus ();
  logic scl = 1'b1;
  logic sda = 1'b1;
  assign bus.scl_pad_i = scl;
  assign bus.sda_pad_i = sda;

  i2c_bus_monitor #(.FILTER_LEN(FILTER_LEN)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int check_count = 0;
  int error_count = 0;
  int hp = 20;

  logic [14:0] exp_q[$];
  logic [14:0] obs_q[$];

  bit m_busy = 0;
  int m_bits = 0;
  int m_data = 0;
  bit m_addr = 0;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [14:0] ev(bit s, bit rs, bit sp, bit e, bit v, bit a, bit k, logic [7:0] d);
    return {s, rs, sp, e, v, a, k, d};
  endfunction

  // One record per cycle in which any pulse output fires.
  always @(negedge clk) begin
    if (bus.start_o | bus.rstart_o | bus.stop_o | bus.err_o | bus.byte_valid_o)
      obs_q.push_back(ev(bus.start_o, bus.rstart_o, bus.stop_o, bus.err_o, bus.byte_valid_o,
                         bus.byte_valid_o & bus.byte_is_addr_o, bus.byte_valid_o & bus.byte_ack_o,
                         bus.byte_valid_o ? bus.byte_data_o : 8'h00));
  end

  // Protocol model: m_bits counts SCL rises since the last START or byte boundary (9 per byte).
  task automatic model_start();
    if (!m_busy) exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 8'h00));
    else         exp_q.push_back(ev(0, 1, 0, m_bits != 0, 0, 0, 0, 8'h00));
    m_busy = 1; m_bits = 0; m_data = 0; m_addr = 1;
  endtask

  task automatic model_stop();
    exp_q.push_back(ev(0, 0, 1, m_busy && m_bits != 0, 0, 0, 0, 8'h00));
    m_busy = 0; m_bits = 0; m_data = 0;
  endtask

  task automatic model_rise(input bit d);
    if (!m_busy) return;
    if (m_bits < 8) begin
      m_data = m_data * 2 + int'(d);
      m_bits++;
    end else begin
      exp_q.push_back(ev(0, 0, 0, 0, 1, m_addr, !d, 8'(m_data)));
      m_addr = 0; m_bits = 0; m_data = 0;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_scl(input logic v);
    if (!scl && v) model_rise(sda);
    scl = v;
    wait_cycles(hp);
  endtask

  task automatic set_sda(input logic v);
    logic edge_while_high;
    edge_while_high = scl && (sda != v);
    if (scl && sda && !v) model_start();
    else if (scl && !sda && v) model_stop();
    sda = v;
    wait_cycles(hp);
    if (edge_while_high) check_output("bus_busy", bus.bus_busy_o, m_busy);
  endtask

  // Both lines change in the same cycle: only the SCL edge counts.
  task automatic set_both(input logic sv, input logic dv);
    if (!scl && sv) model_rise(dv);
    scl = sv;
    sda = dv;
    wait_cycles(hp);
  endtask

  task automatic send_bit(input logic b);
    if (scl) set_scl(1'b0);
    set_sda(b);
    set_scl(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(!ack);
  endtask

  // Sr after a NACK needs no extra clock; otherwise the set-up SCL rise is itself a data clock.
  task automatic bus_start();
    if (!(scl && sda)) begin
      if (scl) set_scl(1'b0);
      set_sda(1'b1);
      set_scl(1'b1);
    end
    set_sda(1'b0);
  endtask

  task automatic bus_stop();
    if (!(scl && !sda)) begin
      if (scl) set_scl(1'b0);
      set_sda(1'b0);
      set_scl(1'b1);
    end
    set_sda(1'b1);
  endtask

  task automatic start_with_latency();
    int lat;
    bit found;
    found = 0;
    lat = 0;
    model_start();
    sda = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.start_o) begin
        found = 1;
        lat = i;
      end
    end
    check_output("start_latency", found ? lat : -1, 2 + FILTER_LEN + 1);
    wait_cycles(hp);
    check_output("bus_busy", bus.bus_busy_o, m_busy);
  endtask

  task automatic glitch(input int w);
    sda = 1'b0;
    wait_cycles(w);
    sda = 1'b1;
    if (w >= FILTER_LEN) begin
      model_start();
      model_stop();
    end
    wait_cycles(hp);
    check_output("glitch_busy", bus.bus_busy_o, 1'b0);
  endtask

  task automatic flush(input string tag);
    int n;
    check_output({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_output(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output(tag, {bus.start_o, bus.rstart_o, bus.stop_o, bus.bus_busy_o, bus.byte_valid_o,
                       bus.byte_data_o, bus.byte_ack_o, bus.byte_is_addr_o, bus.err_o}, 16'h0000);
  endtask

  task automatic apply_stimulus();
    int nb;
    // Write A0 ACK, 5C NACK, STOP.
    hp = 20;
    start_with_latency();
    send_byte(8'hA0, 1);
    send_byte(8'h5C, 0);
    bus_stop();
    flush("write");

    // Address A0 NACK, Sr, A1 ACK, FF NACK, STOP.
    bus_start();
    send_byte(8'hA0, 0);
    bus_start();
    send_byte(8'hA1, 1);
    send_byte(8'hFF, 0);
    bus_stop();
    flush("rstart");

    glitch(FILTER_LEN - 1);
    flush("glitch_short");
    glitch(FILTER_LEN);
    flush("glitch_long");

    // STOP after four data bits, then a clean transfer from idle.
    bus_start();
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    bus_stop();
    bus_start();
    send_byte(8'h55, 1);
    bus_stop();
    flush("partial_stop");

    // Simultaneous fall is no START; later rises in idle are ignored.
    set_both(1'b0, 1'b0);
    send_bit(1); send_bit(0);
    set_sda(1'b1);
    bus_start();
    send_byte(8'h96, 1);
    bus_stop();
    flush("same_edge");

    // Asynchronous reset mid-byte, then a full 0x3C transfer.
    bus_start();
    send_bit(0); send_bit(0); send_bit(1); send_bit(1); send_bit(1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    scl = 1'b1;
    sda = 1'b1;
    m_busy = 0; m_bits = 0; m_data = 0; m_addr = 0;
    wait_cycles(5);
    check_reset_outputs("reset_held");
    rst = 1'b0;
    wait_cycles(hp);
    bus_start();
    send_byte(8'h3C, 1);
    bus_stop();
    flush("after_reset");

    for (int t = 0; t < 15; t++) begin
      hp = $urandom_range(8, 14);
      bus_start();
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) bus_start();
        send_byte(8'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 3) == 0) begin
        for (int k = $urandom_range(1, 8); k > 0; k--) send_bit(1'($urandom));
      end
      bus_stop();
      flush("random");
    end
  endtask

  initial begin
    wait_cycles(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_cycles(10);
    apply_stimulus();
    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
